hub75_scan_scheduler: RTL and testbench
=======================================

# hub75_scan_scheduler

Sequences the HUB75 panel drive for one 64x32 display from the read side of the double-buffered frame memory. Walks row pairs and 4-bit binary-coded-modulation bit planes, fetching pixel pairs, shifting them out on `hub75_clk`, latching, and timing the output-enable window with binary weights. Owns the frame-boundary buffer swap handshake with the SPI writer, so a swap never tears a frame.

## Interface
- `COLUMNS`, 64, pixels shifted per row.
- `ADDR_BITS`, 4, row-pair address width (16 row pairs).
- `PLANES`, 4, bit planes per colour channel.
- `BASE_OE_CYCLES`, 8, OE-low cycles for bit plane 0.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic is on its rising edge.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run scanning. Sampled only at frame boundaries.
- `mem_addr`  out  10  read address `{row_pair[3:0], column[5:0]}`.
- `mem_data`  in  24  read data, valid 1 cycle after `mem_addr`. `[23:12]` is the top pixel and `[11:0]` the bottom pixel, each `{r[3:0], g[3:0], b[3:0]}`.
- `swap_req`  in  1  level from the writer: new frame complete. Held until `swap_ack`.
- `swap_ack`  out  1  one-cycle pulse; the read buffer flips on this cycle.
- `read_buffer`  out  1  which buffer the reader uses.
- `hub75_red`, `hub75_green`, `hub75_blue`  out  2 each  bit 0 is the top half, bit 1 is the bottom half.
- `hub75_addr`  out  4  row-pair address.
- `hub75_clk`, `hub75_latch`  out  1  shift clock and latch.
- `hub75_oe`  out  1  output enable, active-low.

## Operation
- States: `IDLE`, `PREFETCH`, `SHIFT`, `LATCH`, `GUARD` (macro only), `DISPLAY`.
- Scan order:
  - Row pair 0..15 is the outer loop; bit plane 0..3 is the inner loop.
  - Each (row, plane) runs `PREFETCH` -> `SHIFT` -> `LATCH` -> [`GUARD`] -> `DISPLAY`.
- `PREFETCH` (1 cycle): issue `mem_addr={row,0}`.
- `SHIFT` (2 cycles per column, column 0..63):
  - Phase 0: `hub75_clk=0`; the colour outputs take bit `plane` of `mem_data`, top pixel to bit 0 and bottom pixel to bit 1. `mem_addr` advances to the next column.
  - Phase 1: `hub75_clk=1`; the colour outputs are held.
- `LATCH` (1 cycle): `hub75_latch=1`, `hub75_addr` updates to the current row, `hub75_oe=1`.
- `DISPLAY` (`BASE_OE_CYCLES<<plane` cycles): `hub75_oe=0`. On exit, advance the plane, then the row.
- `hub75_oe` is 1 in every state except `DISPLAY`.
- Frame end (after row 15, plane 3 `DISPLAY`):
  - If `swap_req=1`: pulse `swap_ack` for 1 cycle and toggle `read_buffer` in that same cycle.
  - Then go to `PREFETCH` row 0 if `enable=1`, otherwise `IDLE`.
- `IDLE`:
  - Outputs are at reset values.
  - `swap_req` is still serviced: `swap_ack` is pulsed one cycle after `swap_req` is seen high.
  - Moves to `PREFETCH` row 0 on `enable=1`.
- `enable` falling mid-frame has no effect until the frame boundary.
- `swap_req` rising mid-frame is deferred to the frame boundary. Only one ack is given per request.
- Counters wrap naturally: column at 63 -> 0 and row at 15 -> 0.

## Timing
- Reset values: all outputs are 0 except `hub75_oe=1`; `read_buffer=0`; state is `IDLE`.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous), and any pending swap is dropped.
- Memory read latency is fixed at 1 cycle; `mem_data` is used in the cycle after its address.
- Cycles per (row, plane): 1 + 2·`COLUMNS` + 1 + [1] + `BASE_OE_CYCLES<<plane`.
- Default frame length without the macro: 16·(4·130 + 8·15) = 10240 cycles.
- Frame-boundary transition: `swap_ack` is asserted in the cycle after the last `DISPLAY` cycle. `PREFETCH` follows in the next cycle, using the new buffer.
- OE duration arithmetic is 10 bits wide; `BASE_OE_CYCLES<<(PLANES-1)` must fit in 10 bits.

## Configuration
- `HUB75_GHOST_GUARD_EN`:
  - Defined: a 1-cycle `GUARD` state follows `LATCH` with `hub75_oe=1`, so the row-address change settles before the LEDs light. This suppresses ghosting. Default frame length is 10304 cycles.
  - Undefined: `LATCH` goes directly to `DISPLAY`; frame length is 10240 cycles.

## Test plan
- Reset release, `enable=0` -> `hub75_oe=1` and all other outputs 0 indefinitely; `mem_addr` stays 0.
- `enable=1`, memory returns `24'hFFF_000` for every address -> 64 `hub75_clk` rises per plane, `hub75_red` / `hub75_green` / `hub75_blue` all read `2'b01`, and OE-low windows are 8/16/32/64 cycles.
- Per-pixel BCM integration, as in the controller bench: sum `hub75_oe=0` cycles per lit pixel bit over one frame. A top pixel of `12'h5A3` yields weights r=5·8, g=10·8, b=3·8 cycles.
- Row sequencing -> `hub75_addr` takes 0..15 in order, changes only in `LATCH`, never while `hub75_oe=0`; the frame ends at cycle 10240 (10304 with the macro).
- `swap_req` raised at cycle 100 -> one `swap_ack` pulse at frame end, `read_buffer` flips 0 -> 1, and no ack mid-frame. A request raised in `IDLE` is acked in the next cycle.
- Reset pulsed during `DISPLAY` of row 7 -> `hub75_oe=1` immediately; after release the block restarts at row 0, plane 0 with `read_buffer=0`.

Source files
------------

// File: rtl/hub75_scan_scheduler.sv
// hub75_scan_scheduler
//
// Drives one 64x32 HUB75 panel from the read side of a double-buffered
// frame memory. Row pairs form the outer loop and the 4 BCM bit planes form
// the inner loop. For each (row, plane) the block prefetches column 0,
// shifts 64 pixel pairs out on hub75_clk, latches the row, and then holds
// OE low for BASE_OE_CYCLES << plane cycles. At the frame boundary it acks
// a pending buffer swap from the SPI writer, so a frame is never torn.
//
// Optional feature macro: HUB75_GHOST_GUARD_EN
//   Defined   : a 1-cycle GUARD state (OE still high) follows LATCH, so the
//               row address settles before the LEDs light.
//   Undefined : LATCH goes straight to DISPLAY.
//
// Ports
//   clk          in   system clock, rising edge
//   n_reset      in   asynchronous active-low reset
//   enable       in   run scanning; sampled only at frame boundaries
//   mem_addr     out  {row_pair, column} read address
//   mem_data     in   read data one cycle after mem_addr; [23:12] top pixel,
//                     [11:0] bottom pixel, each {r[3:0], g[3:0], b[3:0]}
//   swap_req     in   writer has a new frame; held until swap_ack
//   swap_ack     out  one-cycle pulse; read_buffer flips in the same cycle
//   read_buffer  out  buffer currently read
//   hub75_red/green/blue  out  bit 0 top half, bit 1 bottom half
//   hub75_addr   out  row-pair address shown to the panel
//   hub75_clk    out  shift clock
//   hub75_latch  out  latch strobe
//   hub75_oe     out  output enable, active-low
module hub75_scan_scheduler #(
  parameter int COLUMNS        = 64,
  parameter int ADDR_BITS      = 4,
  parameter int PLANES         = 4,
  parameter int BASE_OE_CYCLES = 8
) (
  input  logic                                 clk,
  input  logic                                 n_reset,
  input  logic                                 enable,
  output logic [ADDR_BITS+$clog2(COLUMNS)-1:0] mem_addr,
  input  logic [6*PLANES-1:0]                  mem_data,
  input  logic                                 swap_req,
  output logic                                 swap_ack,
  output logic                                 read_buffer,
  output logic [1:0]                           hub75_red,
  output logic [1:0]                           hub75_green,
  output logic [1:0]                           hub75_blue,
  output logic [ADDR_BITS-1:0]                 hub75_addr,
  output logic                                 hub75_clk,
  output logic                                 hub75_latch,
  output logic                                 hub75_oe
);

  localparam int COL_BITS   = $clog2(COLUMNS);
  localparam int PLANE_BITS = $clog2(PLANES);

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    LATCH,
    GUARD,
    DISPLAY
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_BITS-1:0]  row_reg, row_next;
  logic [PLANE_BITS-1:0] plane_reg, plane_next;
  logic [COL_BITS-1:0]   col_reg, col_next;
  logic                  phase_reg, phase_next;
  logic [9:0]            oe_cnt_reg, oe_cnt_next;
  logic [ADDR_BITS-1:0]  addr_reg, addr_next;
  logic [1:0]            red_reg, red_next;
  logic [1:0]            green_reg, green_next;
  logic [1:0]            blue_reg, blue_next;
  logic                  swap_ack_reg, swap_ack_next;
  logic                  read_buffer_reg, read_buffer_next;

  // Per-channel nibbles of the pixel pair currently on mem_data.
  logic [PLANES-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;
  assign top_r = mem_data[6*PLANES-1 -: PLANES];
  assign top_g = mem_data[5*PLANES-1 -: PLANES];
  assign top_b = mem_data[4*PLANES-1 -: PLANES];
  assign bot_r = mem_data[3*PLANES-1 -: PLANES];
  assign bot_g = mem_data[2*PLANES-1 -: PLANES];
  assign bot_b = mem_data[PLANES-1 -: PLANES];

  logic [1:0] shift_red, shift_green, shift_blue;
  assign shift_red   = {bot_r[plane_reg], top_r[plane_reg]};
  assign shift_green = {bot_g[plane_reg], top_g[plane_reg]};
  assign shift_blue  = {bot_b[plane_reg], top_b[plane_reg]};

  logic [COL_BITS-1:0] col_inc;
  logic [9:0]          oe_len;
  logic                last_display;
  logic                frame_last;
  logic                swap_pending;

  assign col_inc      = col_reg + COL_BITS'(1);
  assign oe_len       = 10'(BASE_OE_CYCLES) << plane_reg;
  assign last_display = (state_reg == DISPLAY) && (oe_cnt_reg == 10'd0);
  assign frame_last   = last_display && (plane_reg == PLANE_BITS'(PLANES-1)) && (row_reg == '1);
  // A request already acked this cycle is not a new one: the writer still
  // holds swap_req high during the ack cycle.
  assign swap_pending = swap_req && !swap_ack_reg;

  always_comb begin
    state_next       = state_reg;
    row_next         = row_reg;
    plane_next       = plane_reg;
    col_next         = col_reg;
    phase_next       = phase_reg;
    oe_cnt_next      = oe_cnt_reg;
    addr_next        = addr_reg;
    red_next         = red_reg;
    green_next       = green_reg;
    blue_next        = blue_reg;
    swap_ack_next    = 1'b0;
    read_buffer_next = read_buffer_reg;

    // Swaps are only honoured between frames: while idle, or on the last
    // DISPLAY cycle of row 15 / plane 3.
    if ((state_reg == IDLE || frame_last) && swap_pending) begin
      swap_ack_next    = 1'b1;
      read_buffer_next = ~read_buffer_reg;
    end

    case (state_reg)
      IDLE: begin
        row_next   = '0;
        plane_next = '0;
        col_next   = '0;
        phase_next = 1'b0;
        // Hold off one cycle while an ack is due so PREFETCH reads the
        // new buffer.
        if (enable && !swap_pending) state_next = PREFETCH;
      end
      PREFETCH: begin
        col_next   = '0;
        phase_next = 1'b0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
          red_next   = shift_red;
          green_next = shift_green;
          blue_next  = shift_blue;
        end else begin
          phase_next = 1'b0;
          col_next   = col_inc;
          if (col_reg == COL_BITS'(COLUMNS-1)) state_next = LATCH;
        end
      end
      LATCH: begin
        addr_next   = row_reg;
        oe_cnt_next = oe_len - 10'd1;
`ifdef HUB75_GHOST_GUARD_EN
        state_next  = GUARD;
`else
        state_next  = DISPLAY;
`endif
      end
      GUARD: begin
        state_next = DISPLAY;
      end
      DISPLAY: begin
        if (oe_cnt_reg != 10'd0) begin
          oe_cnt_next = oe_cnt_reg - 10'd1;
        end else begin
          if (plane_reg == PLANE_BITS'(PLANES-1)) begin
            plane_next = '0;
            row_next   = row_reg + ADDR_BITS'(1);
          end else begin
            plane_next = plane_reg + PLANE_BITS'(1);
          end
          // The swap-ack cycle is spent in IDLE; scanning resumes from
          // there in the following cycle if enable is still high.
          if (frame_last && (swap_pending || !enable)) state_next = IDLE;
          else                                         state_next = PREFETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg       <= IDLE;
      row_reg         <= '0;
      plane_reg       <= '0;
      col_reg         <= '0;
      phase_reg       <= 1'b0;
      oe_cnt_reg      <= '0;
      addr_reg        <= '0;
      red_reg         <= '0;
      green_reg       <= '0;
      blue_reg        <= '0;
      swap_ack_reg    <= 1'b0;
      read_buffer_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      row_reg         <= row_next;
      plane_reg       <= plane_next;
      col_reg         <= col_next;
      phase_reg       <= phase_next;
      oe_cnt_reg      <= oe_cnt_next;
      addr_reg        <= addr_next;
      red_reg         <= red_next;
      green_reg       <= green_next;
      blue_reg        <= blue_next;
      swap_ack_reg    <= swap_ack_next;
      read_buffer_reg <= read_buffer_next;
    end
  end

  // Outputs decode directly from state so an asynchronous reset drives
  // them to their idle values at once.
  always_comb begin
    mem_addr    = '0;
    hub75_red   = '0;
    hub75_green = '0;
    hub75_blue  = '0;
    hub75_addr  = '0;
    if (state_reg != IDLE) begin
      hub75_addr  = (state_reg == LATCH) ? row_reg : addr_reg;
      hub75_red   = red_reg;
      hub75_green = green_reg;
      hub75_blue  = blue_reg;
      if (state_reg == SHIFT) begin
        // Column c's data arrives while column c-1 is being clocked, so
        // the address runs one column ahead (63 wraps to 0, unused).
        mem_addr = {row_reg, col_inc};
        if (!phase_reg) begin
          hub75_red   = shift_red;
          hub75_green = shift_green;
          hub75_blue  = shift_blue;
        end
      end else begin
        mem_addr = {row_reg, {COL_BITS{1'b0}}};
      end
    end
  end

  assign hub75_clk   = (state_reg == SHIFT) && phase_reg;
  assign hub75_latch = (state_reg == LATCH);
  assign hub75_oe    = (state_reg != DISPLAY);
  assign swap_ack    = swap_ack_reg;
  assign read_buffer = read_buffer_reg;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
module tb_hub75_scan_scheduler;

`ifdef HUB75_GHOST_GUARD_EN
  localparam int FRAME = 10304;
`else
  localparam int FRAME = 10240;
`endif

  logic        clk = 1'b0;
  logic        n_reset;
  logic        enable;
  logic [9:0]  mem_addr;
  logic [23:0] mem_data = '0;
  logic        swap_req;
  logic        swap_ack;
  logic        read_buffer;
  logic [1:0]  hub75_red, hub75_green, hub75_blue;
  logic [3:0]  hub75_addr;
  logic        hub75_clk, hub75_latch, hub75_oe;

  hub75_scan_scheduler dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .enable      (enable),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .read_buffer (read_buffer),
    .hub75_red   (hub75_red),
    .hub75_green (hub75_green),
    .hub75_blue  (hub75_blue),
    .hub75_addr  (hub75_addr),
    .hub75_clk   (hub75_clk),
    .hub75_latch (hub75_latch),
    .hub75_oe    (hub75_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: buffer 0 is all top-white / bottom-black, buffer 1 holds a
  // single pixel pair at row 3, column 10.
  function automatic logic [23:0] mem_fn(input logic b, input logic [9:0] a);
    if (!b) return 24'hFFF000;
    if (a == 10'h0CA) return 24'h5A30C0;
    return 24'h000000;
  endfunction

  always @(posedge clk) mem_data <= mem_fn(read_buffer, mem_addr);

  // Expected {red, green, blue} (bit 1 bottom, bit 0 top) for one column.
  function automatic logic [5:0] exp_colour(input logic b, input int row, input int col, input int p);
    logic [23:0] w;
    w = mem_fn(b, {row[3:0], col[5:0]});
    return {w[8+p], w[20+p], w[4+p], w[16+p], w[p], w[12+p]};
  endfunction

  typedef struct {
    int   cyc;
    logic rb;
  } ack_t;

  logic [5:0] pix_q[$];
  int         latch_q[$];
  int         oe_q[$];
  ack_t       ack_q[$];
  int         latch_cyc[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_frame(input logic b);
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 4; p++) begin
        for (int c = 0; c < 64; c++) pix_q.push_back(exp_colour(b, r, c, p));
        latch_q.push_back(r);
        oe_q.push_back(8 << p);
      end
  endtask

  task automatic push_ack(input int c, input logic rb);
    ack_t a;
    a.cyc = c;
    a.rb  = rb;
    ack_q.push_back(a);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_clk = 1'b0;
  logic       prev_oe = 1'b1;
  int         oe_run = 0;
  int         rise_cnt = 0;
  logic [5:0] shift_pix10 = '0;
  logic [5:0] latched_pix = '0;
  int         latched_row = 0;
  logic       integ_on = 1'b0;
  int         acc_tr = 0, acc_tg = 0, acc_tb = 0;
  int         acc_br = 0, acc_bg = 0, acc_bb = 0;

  always @(negedge clk) begin
    if (!n_reset) begin
      prev_clk = 1'b0;
      prev_oe  = 1'b1;
      oe_run   = 0;
      rise_cnt = 0;
    end else begin
      if (hub75_clk && !prev_clk) begin
        if (pix_q.size() == 0) note_fail("pixel_unexpected");
        else check("pixel", {hub75_red, hub75_green, hub75_blue}, pix_q.pop_front());
        if (rise_cnt == 10) shift_pix10 = {hub75_red, hub75_green, hub75_blue};
        rise_cnt++;
      end
      if (hub75_latch) begin
        check("shift_count", rise_cnt, 64);
        rise_cnt = 0;
        if (latch_q.size() == 0) note_fail("latch_unexpected");
        else check("latch_row", hub75_addr, latch_q.pop_front());
        latch_cyc.push_back(cyc);
        latched_pix = shift_pix10;
        latched_row = int'(hub75_addr);
      end
      if (!hub75_oe) begin
        oe_run++;
        check("addr_stable_oe_low", hub75_addr, latched_row);
        if (integ_on && latched_row == 3) begin
          acc_tr += int'(latched_pix[4]);
          acc_tg += int'(latched_pix[2]);
          acc_tb += int'(latched_pix[0]);
          acc_br += int'(latched_pix[5]);
          acc_bg += int'(latched_pix[3]);
          acc_bb += int'(latched_pix[1]);
        end
      end
      if (hub75_oe && !prev_oe) begin
        if (oe_q.size() == 0) note_fail("oe_window_unexpected");
        else check("oe_window_len", oe_run, oe_q.pop_front());
        oe_run = 0;
      end
      if (swap_ack) begin
        if (ack_q.size() == 0) note_fail("swap_ack_unexpected");
        else begin
          ack_t a;
          a = ack_q.pop_front();
          check("swap_ack_cycle", cyc, a.cyc);
          check("read_buffer_at_ack", read_buffer, a.rb);
        end
      end
      prev_clk = hub75_clk;
      prev_oe  = hub75_oe;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_latches(input int n, input int limit, input string name);
    int t;
    t = 0;
    while (latch_cyc.size() < n && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    if (latch_cyc.size() < n) note_fail(name);
  endtask

  task automatic wait_ack(input int limit, input string name);
    int t;
    t = 0;
    while (!swap_ack && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    if (!swap_ack) note_fail(name);
  endtask

  initial begin
    int k, j, base, target;
    n_reset  = 1'b0;
    enable   = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_oe", hub75_oe, 1);
    check("reset_outputs", {hub75_red, hub75_green, hub75_blue, hub75_addr, hub75_clk, hub75_latch, swap_ack}, 0);
    check("reset_read_buffer", read_buffer, 0);
    n_reset = 1'b1;

    // Idle with enable low: nothing moves.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("idle_oe", hub75_oe, 1);
      check("idle_outputs", {hub75_red, hub75_green, hub75_blue, hub75_addr, hub75_clk, hub75_latch, swap_ack}, 0);
      check("idle_mem_addr", mem_addr, 0);
    end

    // Frames 1 and 2 from buffer 0, frame 3 from buffer 1 after the swap.
    push_frame(1'b0);
    push_frame(1'b0);
    push_frame(1'b1);
    k = cyc;
    enable = 1'b1;
    push_ack(k + 1 + 2 * FRAME, 1'b1);

    wait_latches(65, 2 * FRAME + 200, "frame2_start_timeout");
    if (latch_cyc.size() >= 65) begin
      check("first_latch_cycle", latch_cyc[0], k + 130);
      check("frame_length", latch_cyc[64] - latch_cyc[0], FRAME);
    end

    // Request raised mid-frame 2: must be deferred to the frame end.
    repeat (100) @(posedge clk);
    #1;
    swap_req = 1'b1;
    wait_ack(FRAME + 200, "frame_end_ack_timeout");
    swap_req = 1'b0;
    integ_on = 1'b1;

    // Drop enable mid-frame 3; the frame still completes.
    repeat (1000) @(posedge clk);
    #1;
    enable = 1'b0;
    target = k + 3 * FRAME + 3;
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    integ_on = 1'b0;
    check("bcm_top_r", acc_tr, 40);
    check("bcm_top_g", acc_tg, 80);
    check("bcm_top_b", acc_tb, 24);
    check("bcm_bot_r", acc_br, 0);
    check("bcm_bot_g", acc_bg, 96);
    check("bcm_bot_b", acc_bb, 0);
    check("pix_q_drained", pix_q.size(), 0);
    check("latch_q_drained", latch_q.size(), 0);
    check("oe_q_drained", oe_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    check("latch_total", latch_cyc.size(), 192);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("stopped_mem_addr", mem_addr, 0);
      check("stopped_oe", hub75_oe, 1);
    end

    // Two swaps requested in IDLE, each acked in the next cycle.
    for (int s = 0; s < 2; s++) begin
      j = cyc;
      push_ack(j + 1, (s == 0) ? 1'b0 : 1'b1);
      swap_req = 1'b1;
      wait_ack(4, "idle_ack_timeout");
      swap_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    check("idle_acks_consumed", ack_q.size(), 0);
    check("read_buffer_after_idle_swaps", read_buffer, 1);

    // Restart from buffer 1 and reset during row 7's DISPLAY.
    push_frame(1'b1);
    enable = 1'b1;
    wait_latches(192 + 29, FRAME, "row7_latch_timeout");
    j = 0;
    while (hub75_oe && j < 40) begin
      @(posedge clk); #1;
      j++;
    end
    check("row7_display_reached", hub75_oe, 0);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_reset_oe", hub75_oe, 1);
    check("async_reset_read_buffer", read_buffer, 0);
    check("async_reset_outputs", {hub75_red, hub75_green, hub75_blue, hub75_addr, hub75_latch, hub75_clk}, 0);
    pix_q.delete();
    latch_q.delete();
    oe_q.delete();
    ack_q.delete();
    push_frame(1'b0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    k = cyc;
    base = latch_cyc.size();
    wait_latches(base + 5, 2000, "restart_timeout");
    if (latch_cyc.size() >= base + 5)
      check("restart_latch_cycle", latch_cyc[base], k + 130);
    check("restart_read_buffer", read_buffer, 0);

    enable = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
